icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (PC out, INSTRUCTION in) and a multi-cycle instruction memory.
- Supplies one 19-bit instruction per cycle on a hit. Asserts BUSYWAIT to stall the CPU while a line is filled from memory.
- The CPU holds PC and suppresses register write-back while BUSYWAIT is high.

Parameters:
- ADDR_WIDTH, 32, PC width; PC is a word address, one instruction per word.
- INSTR_WIDTH, 19, instruction width.
- LINES, 8, number of cache lines (power of two).
- WORDS_PER_LINE, 4, instructions per line (power of two).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- PC  input  ADDR_WIDTH  fetch address from the CPU.
- INSTRUCTION  output  INSTR_WIDTH  fetched instruction; valid when BUSYWAIT=0.
- BUSYWAIT  output  1  stall request to the CPU.
- MEM_READ  output  1  memory read request.
- MEM_ADDRESS  output  ADDR_WIDTH-log2(WORDS_PER_LINE)  line (block) address.
- MEM_READDATA  input  INSTR_WIDTH*WORDS_PER_LINE  full line; word 0 in the LSBs.
- MEM_BUSYWAIT  input  1  memory busy; low means MEM_READDATA is valid this cycle.

Behaviour:
- Clock and reset: single clock CLK; RESET is synchronous and active-high.
- Address split: offset = PC[1:0]; index = PC[4:2]; tag = PC[31:5] (27 bits at defaults).
- Storage per line: valid bit, tag, WORDS_PER_LINE instruction words.
- hit = valid[index] & (tag_store[index] == tag). hit is combinational from PC.
- FSM states, two-bit encoding: IDLE, FETCH.
- IDLE, hit:
  - BUSYWAIT=0; INSTRUCTION = data[index][offset], same cycle (zero-latency hit).
- IDLE, miss:
  - BUSYWAIT=1 combinationally; INSTRUCTION = 0.
  - Latch PC[31:2] into the fill-address register.
  - Next state FETCH.
- FETCH:
  - MEM_READ=1; MEM_ADDRESS = latched fill address; BUSYWAIT=1; INSTRUCTION=0.
  - While MEM_BUSYWAIT=1: remain in FETCH.
  - On the posedge where MEM_BUSYWAIT=0: write MEM_READDATA into the line, write the tag, set valid; next state IDLE.
- Miss penalty: 1 (lookup) + memory latency cycles. The following cycle re-looks up PC and hits.
- MEM_READ is registered-state-derived. It is 0 in IDLE and never glitches high on a hit.
- PC changing during FETCH is a CPU protocol violation. The fill still completes to the latched address, and the lookup after the return uses the current PC.
- Reset (including mid-FETCH):
  - All valid bits cleared; state IDLE.
  - MEM_READ=0 from the cycle after RESET is sampled; the in-flight fill is discarded and its line stays invalid.
  - While RESET=1: BUSYWAIT=0, INSTRUCTION=0.
  - Tags and data are not reset.
- A conflict miss replaces the line unconditionally; there is no dirty state.
- Back-to-back misses pass through IDLE for one cycle between fills.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined:
  - Adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - HIT_COUNT increments on each IDLE cycle with hit=1 and RESET=0.
  - MISS_COUNT increments on each IDLE to FETCH transition.
  - Both counters wrap at 2^32 and are cleared by RESET.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - INSTR_WIDTH and ADDR_WIDTH defaults.
  - State encoding constants ICACHE_IDLE=2'b00, ICACHE_FETCH=2'b01.
  - Derived index, offset and tag width constants.
- One sub-module: icache_tag_compare (valid and tag comparison producing hit). It is shared later with a data cache.
- Storage arrays and the FSM live in icache_fetch.

Test Plan:
- Cold miss: RESET, then PC=0, memory latency 3, line {0x00004,0x00003,0x00002,0x00001} → BUSYWAIT high for 4 cycles, MEM_ADDRESS=0 with MEM_READ high, then INSTRUCTION=0x00001 with BUSYWAIT=0.
- Sequential hits: after the fill, PC=1,2,3 on consecutive cycles → INSTRUCTION=0x00002,0x00003,0x00004; BUSYWAIT stays 0; MEM_READ stays 0.
- Conflict miss: PC=32 (same index 0, tag 1) → refill with MEM_ADDRESS=8; then PC=0 → miss again and MEM_ADDRESS=0.
- Reset mid-fill: RESET pulsed in the second FETCH cycle → MEM_READ=0 next cycle; PC=0 then misses (line 0 invalid).
- Line boundary: PC=3 hit, then PC=4 → miss on index 1, MEM_ADDRESS=1.
- With ICACHE_PERF_EN: the sequence above from reset → HIT_COUNT and MISS_COUNT match scoreboard counts exactly (e.g. MISS_COUNT=1, HIT_COUNT=4 after the first two scenarios).

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction cache and its
// tag-compare helper.
package icache_pkg;

    localparam int ICACHE_ADDR_WIDTH  = 32;
    localparam int ICACHE_INSTR_WIDTH = 19;
    localparam int ICACHE_LINES       = 8;
    localparam int ICACHE_WORDS       = 4;

    localparam int ICACHE_OFFSET_W = $clog2(ICACHE_WORDS);
    localparam int ICACHE_INDEX_W  = $clog2(ICACHE_LINES);
    localparam int ICACHE_TAG_W    = ICACHE_ADDR_WIDTH - ICACHE_INDEX_W - ICACHE_OFFSET_W;

    typedef enum logic [1:0] {
        ICACHE_IDLE  = 2'b00,
        ICACHE_FETCH = 2'b01
    } icache_state_e;

endpackage

// File: rtl/icache_tag_compare.sv
// Valid/tag comparison for a direct-mapped lookup; reused by the data cache.
module icache_tag_compare #(
    parameter int TAG_W = 27
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] stored_tag,
    input  logic [TAG_W-1:0] tag,
    output logic             hit
);

    assign hit = valid && (stored_tag == tag);

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with zero-latency hits and a
// two-state line-fill FSM. Optional hit/miss counters under ICACHE_PERF_EN.
module icache_fetch
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = ICACHE_ADDR_WIDTH,
    parameter int INSTR_WIDTH    = ICACHE_INSTR_WIDTH,
    parameter int LINES          = ICACHE_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [ADDR_WIDTH-1:0]                 PC,
    output logic [INSTR_WIDTH-1:0]                INSTRUCTION,
    output logic                                  BUSYWAIT,
    output logic                                  MEM_READ,
    output logic [ADDR_WIDTH-$clog2(WORDS_PER_LINE)-1:0] MEM_ADDRESS,
    input  logic [INSTR_WIDTH*WORDS_PER_LINE-1:0] MEM_READDATA,
    input  logic                                  MEM_BUSYWAIT
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                           HIT_COUNT,
    output logic [31:0]                           MISS_COUNT
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int BLK_W = ADDR_WIDTH - OFF_W;

    logic [LINES-1:0]                             valid;
    logic [TAG_W-1:0]                             tag_store  [LINES];
    logic [WORDS_PER_LINE-1:0][INSTR_WIDTH-1:0]   data_store [LINES];

    icache_state_e    state, state_nxt;
    logic [BLK_W-1:0] fill_addr;
    logic             hit;
    logic             miss_start;
    logic             fill_done;

    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;

    assign offset     = PC[OFF_W-1:0];
    assign index      = PC[OFF_W +: IDX_W];
    assign tag        = PC[ADDR_WIDTH-1 -: TAG_W];
    assign fill_index = fill_addr[IDX_W-1:0];
    assign fill_tag   = fill_addr[BLK_W-1 -: TAG_W];

    icache_tag_compare #(.TAG_W(TAG_W)) u_tag_compare (
        .valid      (valid[index]),
        .stored_tag (tag_store[index]),
        .tag        (tag),
        .hit        (hit)
    );

    // Fill lands on the edge where memory drops its busy flag, unless reset
    // wins on that same edge.
    assign fill_done   = (state == ICACHE_FETCH) && !MEM_BUSYWAIT && !RESET;
    assign MEM_ADDRESS = fill_addr;

    always_comb begin
        state_nxt   = state;
        BUSYWAIT    = 1'b0;
        INSTRUCTION = '0;
        MEM_READ    = 1'b0;
        miss_start  = 1'b0;
        case (state)
            ICACHE_IDLE: begin
                if (!RESET) begin
                    if (hit) begin
                        INSTRUCTION = data_store[index][offset];
                    end else begin
                        BUSYWAIT   = 1'b1;
                        miss_start = 1'b1;
                        state_nxt  = ICACHE_FETCH;
                    end
                end
            end
            ICACHE_FETCH: begin
                MEM_READ = 1'b1;
                BUSYWAIT = !RESET;
                if (!MEM_BUSYWAIT)
                    state_nxt = ICACHE_IDLE;
            end
            default: state_nxt = ICACHE_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ICACHE_IDLE;
            valid <= '0;
        end else begin
            state <= state_nxt;
            if (fill_done)
                valid[fill_index] <= 1'b1;
        end
    end

    // Tags, data and the fill address are deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (miss_start)
            fill_addr <= PC[ADDR_WIDTH-1:OFF_W];
        if (fill_done) begin
            data_store[fill_index] <= MEM_READDATA;
            tag_store[fill_index]  <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if (state == ICACHE_IDLE && hit)
                HIT_COUNT <= HIT_COUNT + 32'd1;
            if (miss_start)
                MISS_COUNT <= MISS_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: the driver queues expected instructions
// and fill addresses, a negedge monitor pops and compares them.
module tb_icache_fetch;

    localparam int AW  = 32;
    localparam int IW  = 19;
    localparam int WPL = 4;
    localparam int BW  = AW - 2;
    localparam int LAT = 3;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [AW-1:0]     PC;
    logic [IW-1:0]     INSTRUCTION;
    logic              BUSYWAIT;
    logic              MEM_READ;
    logic [BW-1:0]     MEM_ADDRESS;
    logic [IW*WPL-1:0] MEM_READDATA;
    logic              MEM_BUSYWAIT;
`ifdef ICACHE_PERF_EN
    logic [31:0]       HIT_COUNT;
    logic [31:0]       MISS_COUNT;
`endif

    icache_fetch dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;
    logic [IW-1:0] exp_q  [$];
    logic [BW-1:0] addr_q [$];
    logic          mr_prev = 1'b0;
    int            mcnt = 0;

    // Memory: word w of block b holds b*4+w+1; data is ready on the
    // LAT-th cycle of a request.
    always @(posedge CLK) mcnt <= MEM_READ ? mcnt + 1 : 0;

    always_comb begin
        MEM_READDATA = '0;
        MEM_BUSYWAIT = !(MEM_READ && mcnt == LAT - 1);
        for (int w = 0; w < WPL; w++)
            MEM_READDATA[w*IW +: IW] = IW'(32'(MEM_ADDRESS) * 4 + 32'(w) + 1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
            chk("rst_instruction", 32'(INSTRUCTION), 32'd0);
        end else if (BUSYWAIT) begin
            chk("stall_instruction", 32'(INSTRUCTION), 32'd0);
            if (MEM_READ && !mr_prev) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_fill: got address %0h expected none", MEM_ADDRESS);
                end else begin
                    chk("mem_address", 32'(MEM_ADDRESS), 32'(addr_q.pop_front()));
                end
            end
        end else begin
            chk("hit_mem_read", 32'(MEM_READ), 32'd0);
            if (exp_q.size() != 0)
                chk("instruction", 32'(INSTRUCTION), 32'(exp_q.pop_front()));
        end
        mr_prev = MEM_READ;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Count stalled cycles until the output is presented, bounded.
    task automatic wait_out(input string name, input int exp_busy);
        int n = 0;
        forever begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            n++;
            if (n > 50) begin
                checks++;
                fails++;
                $display("FAIL %s_timeout: got %0d stall cycles expected %0d", name, n, exp_busy);
                return;
            end
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    task automatic issue(input logic [AW-1:0] pc, input logic [IW-1:0] instr,
                         input bit miss, input logic [BW-1:0] addr);
        PC = pc;
        exp_q.push_back(instr);
        if (miss) addr_q.push_back(addr);
    endtask

    task automatic fetch(input string name, input logic [AW-1:0] pc, input logic [IW-1:0] instr,
                         input bit miss, input logic [BW-1:0] addr, input int busy);
        step();
        issue(pc, instr, miss, addr);
        wait_out(name, busy);
    endtask

    initial begin
        RESET = 1'b1;
        PC    = '0;
        repeat (3) @(posedge CLK);
        #1;

        // Cold miss on PC=0: lookup + 3 memory cycles.
        RESET = 1'b0;
        issue(32'd0, 19'h00001, 1'b1, 30'd0);
        wait_out("cold_miss", 4);

        fetch("seq_hit1", 32'd1, 19'h00002, 1'b0, '0, 0);
        fetch("seq_hit2", 32'd2, 19'h00003, 1'b0, '0, 0);
        fetch("seq_hit3", 32'd3, 19'h00004, 1'b0, '0, 0);

        step();
`ifdef ICACHE_PERF_EN
        chk("hit_count_early", HIT_COUNT, 32'd4);
        chk("miss_count_early", MISS_COUNT, 32'd1);
`endif
        // Conflict miss on index 0 with tag 1, then the original line back.
        issue(32'd32, 19'h00021, 1'b1, 30'd8);
        wait_out("conflict_miss", 4);
        fetch("conflict_back", 32'd0, 19'h00001, 1'b1, 30'd0, 4);

        // Reset in the second FETCH cycle of a fill of block 2.
        step();
        PC = 32'd8;
        addr_q.push_back(30'd2);
        @(negedge CLK);
        @(negedge CLK);
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("mem_read_after_reset", 32'(MEM_READ), 32'd0);
        issue(32'd0, 19'h00001, 1'b1, 30'd0);
        wait_out("miss_after_reset", 4);

        // Line boundary: last word of line 0, then first word of line 1.
        fetch("boundary_hit", 32'd3, 19'h00004, 1'b0, '0, 0);
        fetch("boundary_miss", 32'd4, 19'h00005, 1'b1, 30'd1, 4);
        fetch("line1_hit", 32'd5, 19'h00006, 1'b0, '0, 0);

        step();
`ifdef ICACHE_PERF_EN
        chk("hit_count_final", HIT_COUNT, 32'd4);
        chk("miss_count_final", MISS_COUNT, 32'd2);
`endif
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("addr_q_drained", 32'(addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
